// File: rtl/vga_pkg.sv
// Shared VGA timing constants, framebuffer geometry and pixel helpers for the
// scanout path.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int CNT_W = 10;

    localparam int FB_WIDTH      = 320;
    localparam int FB_HEIGHT     = 240;
    localparam int FB_BANK_WORDS = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_W     = 18;

    typedef logic [11:0]          rgb12_t;
    typedef logic [FB_ADDR_W-1:0] fb_addr_t;

    // y*320 as two shifts and an add so no multiplier is inferred.
    function automatic fb_addr_t row_offset(input logic [8:0] y);
        return (fb_addr_t'(y) << 8) + (fb_addr_t'(y) << 6);
    endfunction

    function automatic rgb12_t bar_colour(input logic [2:0] idx);
        return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
    endfunction

endpackage

// File: rtl/framebuffer_scanout_if.sv
// Framebuffer BRAM read port: address out from the scanout, pixel data back
// from the memory.
interface framebuffer_scanout_if;
    import vga_pkg::*;

    fb_addr_t addr_out;
    rgb12_t   data_in;

    modport master (output addr_out, input data_in);
    modport slave  (input addr_out, output data_in);

endinterface

// File: rtl/vga_timing.sv
// Free-running VGA counters with raw (undelayed) sync, active-area and
// frame-start indications.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic             clk_in,
    input  logic             rst_in,
    output logic [CNT_W-1:0] hcount_out,
    output logic [CNT_W-1:0] vcount_out,
    output logic             active_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             frame_start_out
);

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS    = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SS    = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_hcount;
    logic [CNT_W-1:0] r_vcount;
    logic [CNT_W-1:0] w_hcount_nxt;
    logic [CNT_W-1:0] w_vcount_nxt;
    logic             r_frame_start;

    always_comb begin
        w_hcount_nxt = r_hcount + 1'b1;
        w_vcount_nxt = r_vcount;
        if (r_hcount == H_LAST) begin
            w_hcount_nxt = '0;
            w_vcount_nxt = (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
        end
    end

    // Frame start is registered from the next count so it lines up with (0,0).
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_frame_start <= (w_hcount_nxt == '0) && (w_vcount_nxt == '0);
        end
    end

    assign hcount_out      = r_hcount;
    assign vcount_out      = r_vcount;
    assign active_out      = (r_hcount < H_VIS) && (r_vcount < V_VIS);
    assign hsync_out       = !((r_hcount >= H_SS) && (r_hcount < H_SE));
    assign vsync_out       = !((r_vcount >= V_SS) && (r_vcount < V_SE));
    assign frame_start_out = r_frame_start;

endmodule

// File: rtl/framebuffer_scanout.sv
// VGA scanout of a double-buffered 320x240 framebuffer with 2x doubling and
// tear-free bank swaps. Optional macro TEST_PATTERN_EN adds colour-bar output.
module framebuffer_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE     = VGA_H_ACTIVE,
    parameter int H_FP         = VGA_H_FP,
    parameter int H_SYNC       = VGA_H_SYNC,
    parameter int H_BP         = VGA_H_BP,
    parameter int V_ACTIVE     = VGA_V_ACTIVE,
    parameter int V_FP         = VGA_V_FP,
    parameter int V_SYNC       = VGA_V_SYNC,
    parameter int V_BP         = VGA_V_BP,
    parameter int READ_LATENCY = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         switch_in,
`ifdef TEST_PATTERN_EN
    input  logic                         test_pattern_in,
`endif
    framebuffer_scanout_if.master        fb,
    output logic                         display_bank_out,
    output logic                         swap_done_out,
    output logic                         frame_start_out,
    output logic                         hsync_out,
    output logic                         vsync_out,
    output rgb12_t                       rgb_out
);

    localparam int L = READ_LATENCY + 2;
    localparam logic [CNT_W-1:0] V_SWAP = CNT_W'(V_ACTIVE);

    logic [CNT_W-1:0] w_hcount;
    logic [CNT_W-1:0] w_vcount;
    logic             w_active;
    logic             w_hsync;
    logic             w_vsync;
    logic [8:0]       w_y;
    fb_addr_t         w_addr;
    logic             w_swap_pt;
    rgb12_t           w_pix;

    logic             r_bank;
    logic             r_pending;
    logic             r_swap_done;
    fb_addr_t         r_addr;
    logic             r_hsync_p [L];
    logic             r_vsync_p [L];
    logic             r_vld_p   [L-1];
    rgb12_t           r_rgb;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .hcount_out      (w_hcount),
        .vcount_out      (w_vcount),
        .active_out      (w_active),
        .hsync_out       (w_hsync),
        .vsync_out       (w_vsync),
        .frame_start_out (frame_start_out)
    );

    // Stage p0: framebuffer address from the doubled-down screen position.
    assign w_y    = 9'(w_vcount >> 1);
    assign w_addr = (r_bank ? fb_addr_t'(FB_BANK_WORDS) : '0)
                  + row_offset(w_y)
                  + fb_addr_t'(w_hcount >> 1);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_addr <= '0;
        end else begin
            r_addr <= w_addr;
        end
    end

    assign fb.addr_out = r_addr;

    // Swaps happen only on the first blank line, so a frame never mixes banks.
    assign w_swap_pt = (w_hcount == '0) && (w_vcount == V_SWAP);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_bank      <= 1'b0;
            r_pending   <= 1'b0;
            r_swap_done <= 1'b0;
        end else begin
            r_swap_done <= 1'b0;
            if (w_swap_pt && (r_pending || switch_in)) begin
                r_bank      <= ~r_bank;
                r_pending   <= 1'b0;
                r_swap_done <= 1'b1;
            end else if (switch_in) begin
                r_pending   <= 1'b1;
            end
        end
    end

    // Stages p0..p(L-1): sync and active follow the address/BRAM/output path.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < L; i++) begin
                r_hsync_p[i] <= 1'b1;
                r_vsync_p[i] <= 1'b1;
            end
            for (int i = 0; i < L - 1; i++) begin
                r_vld_p[i] <= 1'b0;
            end
        end else begin
            r_hsync_p[0] <= w_hsync;
            r_vsync_p[0] <= w_vsync;
            r_vld_p[0]   <= w_active;
            for (int i = 1; i < L; i++) begin
                r_hsync_p[i] <= r_hsync_p[i-1];
                r_vsync_p[i] <= r_vsync_p[i-1];
            end
            for (int i = 1; i < L - 1; i++) begin
                r_vld_p[i] <= r_vld_p[i-1];
            end
        end
    end

`ifdef TEST_PATTERN_EN
    logic [2:0] r_bar_p [L-1];

    always_ff @(posedge clk_in) begin
        r_bar_p[0] <= w_hcount[9:7];
        for (int i = 1; i < L - 1; i++) begin
            r_bar_p[i] <= r_bar_p[i-1];
        end
    end

    assign w_pix = test_pattern_in ? bar_colour(r_bar_p[L-2]) : fb.data_in;
`else
    assign w_pix = fb.data_in;
`endif

    // Stage p(L-1): output register, blanked outside the visible area.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= r_vld_p[L-2] ? w_pix : '0;
        end
    end

    assign hsync_out        = r_hsync_p[L-1];
    assign vsync_out        = r_vsync_p[L-1];
    assign rgb_out          = r_rgb;
    assign display_bank_out = r_bank;
    assign swap_done_out    = r_swap_done;

endmodule
